// File: rtl/sweep_generator_pkg.sv
// Shared definitions for the staircase sweep generator: code width,
// sequencer state encoding and the saturating step arithmetic.
package sweep_generator_pkg;

    localparam int DAC_WIDTH = 12;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Moves code by step in the requested direction and pins the result to
    // [0, maxCode] instead of wrapping, so a sweep that overshoots stays at the rail.
    function automatic logic [31:0] clampStep(input logic [31:0] code,
                                              input logic [31:0] step,
                                              input logic        up,
                                              input logic [31:0] maxCode);
        logic [32:0] sum;
        logic [31:0] res;
        if (up) begin
            sum = {1'b0, code} + {1'b0, step};
            res = (sum > {1'b0, maxCode}) ? maxCode : sum[31:0];
        end else begin
            sum = '0;
            res = (step > code) ? 32'd0 : code - step;
        end
        return res;
    endfunction

endpackage

// File: rtl/sweep_generator_if.sv
// Parameter/result bundle between the measurement sequencer (master) and the sweep generator (slave).
// There is no valid/ready: parameters are sampled once on the first step-clock edge after reset release.
interface sweep_generator_if
    import sweep_generator_pkg::*;
#(
    parameter int WIDTH = DAC_WIDTH
);
    logic             i_updirection;
    logic [WIDTH-1:0] i_start;
    logic [WIDTH-1:0] i_step;
    logic [WIDTH-1:0] i_steps;
    logic [WIDTH-1:0] i_repeats;
    logic [WIDTH-1:0] o_result;
    logic             o_stepping;

    modport master (
        output i_updirection, i_start, i_step, i_steps, i_repeats,
        input  o_result, o_stepping
    );

    modport slave (
        input  i_updirection, i_start, i_step, i_steps, i_repeats,
        output o_result, o_stepping
    );
endinterface

// File: rtl/sweep_generator_hold_counter.sv
// Dwell counter: holds each sweep point for holdMax+1 enabled cycles and
// flags the cycle on which the point may advance.
module hold_counter
    import sweep_generator_pkg::*;
#(
    parameter int WIDTH = DAC_WIDTH
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             enable,
    input  logic [WIDTH-1:0] holdMax,
    output logic             advance
);
    logic [WIDTH-1:0] holdCnt;

    assign advance = enable && (holdCnt >= holdMax);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            holdCnt <= '0;
        end else if (enable) begin
            if (advance) begin
                holdCnt <= '0;
            end else begin
                holdCnt <= holdCnt + WIDTH'(1);
            end
        end
    end
endmodule

// File: rtl/sweep_generator.sv
// One-shot staircase sweep: loads parameters after reset release, then steps
// o_result by a fixed saturating increment, holding each code R cycles.
module sweep_generator
    import sweep_generator_pkg::*;
#(
    parameter int WIDTH = DAC_WIDTH
) (
    input  logic               i_stepCLK,
    input  logic               i_reset,
    sweep_generator_if.slave   bus,
    output state_t             o_dbgState
);
    state_t           state;
    logic             dirR;
    logic [WIDTH-1:0] stepR;
    logic [WIDTH-1:0] stepsR;
    logic [WIDTH-1:0] holdMaxR;
    logic [WIDTH-1:0] pointCnt;
    logic [WIDTH-1:0] result;
    logic             stepping;
    logic             advance;
    logic [WIDTH-1:0] nextCode;

    assign bus.o_result   = result;
    assign bus.o_stepping = stepping;
    assign o_dbgState     = state;

    assign nextCode = WIDTH'(clampStep(32'(result), 32'(stepR), dirR,
                                       32'({WIDTH{1'b1}})));

    hold_counter #(.WIDTH(WIDTH)) u_holdCounter (
        .clk     (i_stepCLK),
        .resetN  (i_reset),
        .enable  (state == RUN),
        .holdMax (holdMaxR),
        .advance (advance)
    );

    always_ff @(posedge i_stepCLK or negedge i_reset) begin
        if (!i_reset) begin
            state    <= LOAD;
            dirR     <= 1'b0;
            stepR    <= '0;
            stepsR   <= '0;
            holdMaxR <= '0;
            pointCnt <= '0;
            result   <= '0;
            stepping <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    dirR     <= bus.i_updirection;
                    stepR    <= bus.i_step;
                    stepsR   <= bus.i_steps;
                    // A repeat count of 0 behaves as 1, so store R-1 with a floor of 0.
                    holdMaxR <= (bus.i_repeats == '0) ? '0 : bus.i_repeats - WIDTH'(1);
                    pointCnt <= '0;
                    result   <= bus.i_start;
                    stepping <= 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    if (advance) begin
                        if (pointCnt == stepsR) begin
                            stepping <= 1'b0;
                            state    <= DONE;
                        end else begin
                            pointCnt <= pointCnt + WIDTH'(1);
                            result   <= nextCode;
                        end
                    end
                end
                default: begin
                    state <= DONE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sweep_generator.sv
// Bench for sweep_generator: directed sweeps scored against a staircase
// model built from start/step/steps/repeats with plain integer arithmetic.
module tb_sweep_generator;
    import sweep_generator_pkg::*;

    localparam int W = 12;
    localparam int MAXC = 4095;

    logic   clk = 1'b0;
    logic   rstN = 1'b0;
    state_t dbgState;

    sweep_generator_if #(.WIDTH(W)) bus();

    sweep_generator #(.WIDTH(W)) dut (
        .i_stepCLK  (clk),
        .i_reset    (rstN),
        .bus        (bus),
        .o_dbgState (dbgState)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];   // {stepping, result} per cycle
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Code of point k: straight line from start, pinned to the DAC range.
    function automatic int modelCode(input int start, input int step, input bit up, input int k);
        int v;
        v = up ? start + k * step : start - k * step;
        if (v < 0) v = 0;
        if (v > MAXC) v = MAXC;
        return v;
    endfunction

    always @(negedge clk) begin : compare
        logic [W:0] e;
        if (checking && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("result", 32'(bus.o_result), 32'(e[W-1:0]));
            check("stepping", 32'(bus.o_stepping), 32'(e[W]));
        end
    end

    task automatic loadParams(input bit up, input int start, input int step,
                              input int steps, input int repeats);
        bus.i_updirection = up;
        bus.i_start       = W'(start);
        bus.i_step        = W'(step);
        bus.i_steps       = W'(steps);
        bus.i_repeats     = W'(repeats);
    endtask

    // Reset, apply parameters, release between edges and queue the expected trace.
    task automatic startSweep(input bit up, input int start, input int step,
                              input int steps, input int repeats);
        int r;
        checking = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rstN = 1'b0;
        loadParams(up, start, step, steps, repeats);
        @(negedge clk);
        rstN = 1'b1;
        r = (repeats == 0) ? 1 : repeats;
        for (int k = 0; k <= steps; k++)
            for (int j = 0; j < r; j++)
                exp_q.push_back({1'b1, W'(modelCode(start, step, up, k))});
        for (int j = 0; j < 3; j++)
            exp_q.push_back({1'b0, W'(modelCode(start, step, up, steps))});
        @(posedge clk);
        checking = 1'b1;
    endtask

    task automatic waitSweep(input string name);
        for (int c = 0; c < 20000 && exp_q.size() > 0; c++) @(posedge clk);
        check({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
        checking = 1'b0;
    endtask

    initial begin
        loadParams(1'b1, 33, 2, 3, 2);
        #12;
        check("reset_result", 32'(bus.o_result), 32'd0);
        check("reset_stepping", 32'(bus.o_stepping), 32'd0);
        check("reset_state", 32'(dbgState), 32'(LOAD));

        check("model_desc_k0", 32'(modelCode(100, 10, 1'b0, 0)), 32'd100);
        check("model_desc_k5", 32'(modelCode(100, 10, 1'b0, 5)), 32'd50);
        check("model_clamp_k1", 32'(modelCode(4090, 4, 1'b1, 1)), 32'd4094);
        check("model_clamp_k3", 32'(modelCode(4090, 4, 1'b1, 3)), 32'd4095);
        check("model_fs_last", 32'(modelCode(0, 1, 1'b1, 4095)), 32'd4095);

        startSweep(1'b1, 0, 1, 4095, 2);
        waitSweep("fullscale");
        check("fullscale_final", 32'(bus.o_result), 32'd4095);
        check("fullscale_done", 32'(dbgState), 32'(DONE));

        startSweep(1'b0, 100, 10, 5, 1);
        waitSweep("descending");

        startSweep(1'b1, 4090, 4, 3, 1);
        waitSweep("clamp_up");

        startSweep(1'b0, 15, 7, 4, 2);
        waitSweep("clamp_down");
        check("clamp_down_final", 32'(bus.o_result), 32'd0);

        startSweep(1'b1, 7, 3, 0, 0);
        waitSweep("single_point");
        check("single_point_final", 32'(bus.o_result), 32'd7);

        startSweep(1'b1, 200, 0, 2, 3);
        waitSweep("zero_step");

        // Parameter inputs moved mid-run must not disturb the captured sweep.
        startSweep(1'b1, 10, 1, 6, 3);
        repeat (4) @(posedge clk);
        #2 loadParams(1'b0, 999, 5, 0, 1);
        waitSweep("input_change");
        check("input_change_final", 32'(bus.o_result), 32'd16);

        // Asynchronous reset between edges, then restart from a new start code.
        startSweep(1'b1, 40, 3, 20, 2);
        repeat (5) @(posedge clk);
        #3;
        checking = 1'b0;
        exp_q.delete();
        rstN = 1'b0;
        #1;
        check("midreset_result", 32'(bus.o_result), 32'd0);
        check("midreset_stepping", 32'(bus.o_stepping), 32'd0);
        startSweep(1'b1, 500, 3, 4, 2);
        waitSweep("restart");
        check("restart_final", 32'(bus.o_result), 32'd512);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sweep_generator.md
# sweep_generator

Staircase sweep generator driving a 12-bit DAC code. After reset release it emits a one-shot ramp from a programmable start code, moving up or down by a fixed increment, holding each code for a programmable number of step-clock cycles. It sits between the measurement sequencer (which supplies the sweep parameters) and the DAC interface, and flags the active sweep on `o_stepping`.

## Interface
- `WIDTH`, 12, DAC code width and width of all parameter inputs.
- `i_stepCLK` in 1, step clock; all state changes on its rising edge.
- `i_reset` in 1, asynchronous, active-low reset (0 = in reset).
- `i_updirection` in 1, 1 = ascending sweep, 0 = descending.
- `i_start` in WIDTH, first output code.
- `i_step` in WIDTH, code increment per point.
- `i_steps` in WIDTH, number of increments; sweep has `i_steps`+1 points.
- `i_repeats` in WIDTH, clock cycles each point is held (0 treated as 1).
- `o_result` out WIDTH, current DAC code (registered).
- `o_stepping` out 1, high while a sweep is in progress.

## Operation
- States: LOAD, RUN, DONE.
- Reset (asynchronous, `i_reset`=0):
  - state = LOAD;
  - `o_result`=0, `o_stepping`=0;
  - point counter = 0, hold counter = 0.
- LOAD (first rising edge with `i_reset`=1):
  - capture `i_updirection`, `i_step`, `i_steps`, and R = max(`i_repeats`,1) into internal registers;
  - `o_result` <= `i_start`, `o_stepping` <= 1;
  - go to RUN.
- Parameter inputs are ignored after LOAD until the next reset.
- RUN, each edge:
  - if hold counter < R-1: hold counter increments;
  - else if point counter = captured steps: go to DONE, `o_stepping` <= 0, `o_result` unchanged;
  - otherwise: hold counter <= 0, point counter increments, and `o_result` <= `o_result` ± step.
- Arithmetic: computed at WIDTH+1 bits, then clamped to [0, 2^WIDTH−1]. No wrap-around. Once clamped, subsequent points stay at the rail.
- DONE: outputs frozen. Leaving DONE requires reset.
- `i_steps`=0: single point held R cycles.
- `i_step`=0: constant output for (steps+1)·R cycles.
- Reset mid-sweep: immediately returns outputs to 0/0. The sweep restarts from LOAD with freshly sampled inputs.

## Timing
- Latency: `o_result`=`i_start` and `o_stepping`=1 are visible after the first rising edge following reset release.
- Each point is present for exactly R cycles. Code k (k=0..steps) appears at edge 1 + k·R after release.
- `o_stepping` falls at edge 1 + (steps+1)·R. Total active cycles = (steps+1)·R.
- Outputs are registered only, with no combinational paths from inputs.

## Structure
- Shared package holds:
  - the state enum (LOAD, RUN, DONE);
  - the `WIDTH` default (12);
  - the clamp helper function (add/sub with saturation).
- One natural sub-module, `hold_counter`: counts to R−1 and pulses `advance`. The point counter and output register stay in the top level.

## Test plan
- Ascending full-scale, start=0, step=1, steps=4095, repeats=2:
  - `o_result` = 0,0,1,1,…,4095,4095;
  - `o_stepping` high for 8192 cycles, then low with `o_result`=4095.
- Descending, start=100, step=10, steps=5, repeats=1, updirection=0:
  - codes 100,90,80,70,60,50 on consecutive cycles;
  - `o_stepping` falls after 6 cycles.
- Clamp, start=4090, step=4, steps=3, repeats=1, ascending:
  - codes 4090,4094,4095,4095.
- Repeats=0 and steps=0, start=7:
  - `o_result`=7 for one cycle with `o_stepping`=1, then `o_stepping`=0 and `o_result` stays 7.
- Reset mid-sweep:
  - assert `i_reset`=0 asynchronously between edges → `o_result`=0 and `o_stepping`=0 immediately;
  - change `i_start` to 500 and release → sweep restarts at 500.
- Inputs changed during RUN, e.g. `i_step` 1→5: no effect on the remaining sequence.
